// File: rtl/hack_cpu_seq.sv
// Hack CPU fetch/decode/execute sequencer: owns A, D, PC and IR, drives an external
// combinational ALU, and writes results back to A, D and data memory.
module hack_cpu_seq #(
    parameter int WIDTH = 16,
    parameter int AW    = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             rom_req,
    output logic [AW-1:0]    rom_addr,
    input  logic [WIDTH-1:0] rom_data,
    input  logic             rom_valid,
    output logic [AW-1:0]    mem_addr,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_we,
    input  logic             mem_ack,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic             alu_zx,
    output logic             alu_nx,
    output logic             alu_zy,
    output logic             alu_ny,
    output logic             alu_f,
    output logic             alu_no,
    input  logic [WIDTH-1:0] alu_out,
    output logic [AW-1:0]    pc
);

    typedef enum logic [1:0] {
        FETCH,
        EXEC,
        WRITE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] ir;
    logic [WIDTH-1:0] r_reg;
    logic [AW-1:0]    waddr;

    logic c_instr;
    logic ng;
    logic zr;
    logic take;

    // Flags are derived here from the raw result; the ALU's own zr/ng are not needed.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch can be inferred.
        c_instr = ir[WIDTH-1];
        ng      = alu_out[WIDTH-1];
        zr      = (alu_out == '0);
        take    = (ir[2] & ng) | (ir[1] & zr) | (ir[0] & ~ng & ~zr);
    end

    assign rom_addr  = pc;
    assign mem_addr  = (state == WRITE) ? waddr : a_reg[AW-1:0];
    assign mem_wdata = r_reg;
    assign alu_x     = d_reg;
    assign alu_y     = ir[12] ? mem_rdata : a_reg;
    assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = c_instr ? ir[11:6] : 6'b0;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; this is what makes "old A" the jump target and write address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FETCH;
            pc      <= '0;
            a_reg   <= '0;
            d_reg   <= '0;
            ir      <= '0;
            r_reg   <= '0;
            waddr   <= '0;
            mem_we  <= 1'b0;
            rom_req <= 1'b1;
        end else begin
            unique case (state)
                FETCH: begin
                    if (rom_valid) begin
                        ir      <= rom_data;
                        rom_req <= 1'b0;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    if (!c_instr) begin
                        a_reg   <= WIDTH'({1'b0, ir[WIDTH-2:0]});
                        pc      <= pc + AW'(1);
                        rom_req <= 1'b1;
                        state   <= FETCH;
                    end else begin
                        r_reg <= alu_out;
                        if (ir[5]) a_reg <= alu_out;
                        if (ir[4]) d_reg <= alu_out;
                        pc <= take ? a_reg[AW-1:0] : pc + AW'(1);
                        if (ir[3]) begin
                            waddr  <= a_reg[AW-1:0];
                            mem_we <= 1'b1;
                            state  <= WRITE;
                        end else begin
                            rom_req <= 1'b1;
                            state   <= FETCH;
                        end
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        mem_we  <= 1'b0;
                        rom_req <= 1'b1;
                        state   <= FETCH;
                    end
                end
                default: begin
                    rom_req <= 1'b1;
                    mem_we  <= 1'b0;
                    state   <= FETCH;
                end
            endcase
        end
    end

endmodule
